// File: rtl/eif_neuron_scheduler.sv
// Adaptive integrate-and-fire scheduler: one update datapath swept over N_NEURONS virtual neurons per tick.
// Spike events pass through a one-cycle push stage into a small FIFO; pops are ignored when it is empty.

module eif_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop   = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_rdy = !full || do_pop;
  assign do_push  = push && push_rdy;
  assign pop_vld  = !empty;
  assign pop_dat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module eif_neuron_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = $clog2(N_NEURONS),
  parameter int THR_INIT   = 200,
  parameter int THR_DEC    = 10,
  parameter int THR_INC    = 1,
  parameter int THR_MIN    = 20,
  parameter int THR_MAX    = 250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             cur_valid,
  output logic             cur_ready,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  output logic             busy,
  output logic             done,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [IDX_W-1:0] spike_idx,
  output logic             drop_flag,
  output logic             tick_missed
);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} fsm_t;

  localparam logic [7:0]       THR_INIT_B = 8'(THR_INIT);
  localparam logic [8:0]       THR_DEC_W  = 9'(THR_DEC);
  localparam logic [8:0]       THR_INC_W  = 9'(THR_INC);
  localparam logic [8:0]       THR_MIN_W  = 9'(THR_MIN);
  localparam logic [8:0]       THR_MAX_W  = 9'(THR_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  fsm_t             fsm_q, fsm_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       state_q [N_NEURONS];
  logic [7:0]       thr_q   [N_NEURONS];
  logic [7:0]       cur_q   [N_NEURONS];
  logic [N_NEURONS-1:0] hist_q;
  logic             cur_rdy_q, push_vld_q, drop_q, missed_q, fifo_push_rdy;
  logic [IDX_W-1:0] push_idx_q;

  logic [7:0] st_cur, thr_cur, st_nxt, thr_nxt;
  logic [8:0] sum, thr_cur9, thr_w;
  logic       fire, in_update;

  assign in_update = (fsm_q == UPDATE);
  assign st_cur    = state_q[ptr_q];
  assign thr_cur   = thr_q[ptr_q];
  assign thr_cur9  = {1'b0, thr_cur};
  assign fire      = (st_cur >= thr_cur);
  assign sum       = {1'b0, st_cur} + {1'b0, cur_q[ptr_q]};

  always_comb begin
    st_nxt = sum[8] ? 8'hFF : sum[7:0];
    if (fire) st_nxt = st_cur - thr_cur;
    // threshold adapts on the previous sweep's spike, read before hist is overwritten
    if (hist_q[ptr_q]) thr_w = (thr_cur9 >= THR_MIN_W + THR_DEC_W) ? thr_cur9 - THR_DEC_W : THR_MIN_W;
    else               thr_w = (thr_cur9 + THR_INC_W >= THR_MAX_W) ? THR_MAX_W : thr_cur9 + THR_INC_W;
    thr_nxt = thr_w[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        thr_q[i]   <= THR_INIT_B;
        cur_q[i]   <= '0;
      end
      hist_q <= '0;
    end else begin
      if (in_update) begin
        state_q[ptr_q] <= st_nxt;
        thr_q[ptr_q]   <= thr_nxt;
        hist_q[ptr_q]  <= fire;
      end
      if (cur_valid && cur_rdy_q) cur_q[cur_idx] <= cur_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      ptr_q      <= '0;
      cur_rdy_q  <= 1'b0;
      push_vld_q <= 1'b0;
      push_idx_q <= '0;
      drop_q     <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      ptr_q      <= ptr_d;
      cur_rdy_q  <= (fsm_d == IDLE);
      push_vld_q <= in_update && fire;
      push_idx_q <= ptr_q;
      drop_q     <= drop_q || (push_vld_q && !fifo_push_rdy);
      missed_q   <= missed_q || (tick && fsm_q != IDLE);
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    ptr_d = ptr_q;
    busy  = 1'b0;
    done  = 1'b0;
    case (fsm_q)
      IDLE: begin
        ptr_d = '0;
        if (tick) fsm_d = UPDATE;
      end
      UPDATE: begin
        busy = 1'b1;
        if (ptr_q == LAST_IDX) fsm_d = DONE;
        else                   ptr_d = ptr_q + IDX_ONE;
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  eif_fifo #(.W(IDX_W), .DEPTH(FIFO_DEPTH)) u_spike_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld_q),
    .push_dat (push_idx_q),
    .push_rdy (fifo_push_rdy),
    .pop      (spike_ready),
    .pop_vld  (spike_valid),
    .pop_dat  (spike_idx)
  );

  assign cur_ready   = cur_rdy_q;
  assign drop_flag   = drop_q;
  assign tick_missed = missed_q;
endmodule
